m31_inverter: RTL and testbench
===============================

// Module: m31_inverter
// PURPOSE
//  Sequential modular inverter over M31 (p = 2^31-1): out = a^(p-2) mod p (Fermat), i.e. a^-1 for a != 0.
//  Inverse-direction companion to the M31 multiplier: reuses two combinational M31 multipliers
//  (multiply + mod reduce) per iteration, driven by an FSM. Sits beside the multiplier in the
//  arithmetic datapath; used for field division and normalisation. valid/ready on both sides.
// PARAMETERS
//  DATA_WIDTH  31             operand/result width (M31 field element)
//  EXPONENT    31'h7FFFFFFD   exponent applied (p-2); may be overridden for generic powering
//  EXP_BITS    31             number of exponent bits scanned (= iteration count)
//  CNT_WIDTH   5              width of iteration counter ($clog2(EXP_BITS))
// PORTS
//  clk        in   1           clock
//  rst_n      in   1           synchronous reset, active-low
//  in_valid   in   1           operand valid
//  in_ready   out  1           block can accept operand
//  in_data    in   DATA_WIDTH  operand a, any 31-bit value (0x7FFFFFFF treated as 0)
//  out_valid  out  1           result valid
//  out_ready  in   1           consumer accepts result
//  out_data   out  DATA_WIDTH  a^EXPONENT mod p, canonical (< p)
//  out_zero   out  1           operand was congruent to 0 (no inverse; out_data = 0)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_zero=0, cnt=0.
//  FSM: IDLE -> EXP -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&&in_ready: base<=canon(in_data), acc<=1, cnt<=0,
//         zero_q<=(canon(in_data)==0), go EXP. canon(x) = (x==0x7FFFFFFF) ? 0 : x.
//   EXP:  in_ready=0. Right-to-left square-and-multiply, one exponent bit per cycle:
//         if EXPONENT[cnt]: acc<=m31_mul(acc,base); base<=m31_mul(base,base); cnt<=cnt+1.
//         Both products use pre-update base. After iteration cnt==EXP_BITS-1: go DONE,
//         out_data<=final acc, out_zero<=zero_q, out_valid<=1.
//   DONE: out_valid=1, out_data/out_zero held stable until out_ready; on out_valid&&out_ready:
//         out_valid<=0, go IDLE. in_ready stays 0 in DONE (no overlap of result and new operand).
//  Latency: operand accepted at edge N -> out_valid high after edge N+EXP_BITS+1 (32 cycles default).
//   Fixed, data-independent (no early exit for 0/1). Throughput: one op per >=33 cycles.
//  Arithmetic: multipliers produce 62-bit products reduced to canonical [0,p-1]; acc/base always < p.
//   Zero input yields acc=0 naturally (0^k, k>0); out_zero=1 flags it.
//  Boundaries:
//   - in_valid while busy: ignored (in_ready=0); operand must be held by producer.
//   - out_ready low indefinitely: result held, no new operand accepted.
//   - out_ready high in same cycle out_valid rises: handshake completes that cycle; IDLE next.
//   - rst_n low mid-EXP or in DONE: operation discarded, outputs return to reset values next edge.
//   - cnt never wraps: DONE entered exactly at cnt==EXP_BITS-1.
//  out_data/out_zero change only on entry to DONE or on reset.
// TESTING
//  1: a=2 -> out_data=0x40000000, out_zero=0, out_valid 32 cycles after accept.
//  2: a=3 -> 0x55555555; a=1 -> 0x00000001; a=0x7FFFFFFE -> 0x7FFFFFFE.
//  3: a=0 -> out_data=0, out_zero=1; a=0x7FFFFFFF -> out_data=0, out_zero=1.
//  4: backpressure: out_ready=0 for 10 cycles after out_valid -> data stable, in_ready=0,
//     extra in_valid pulses ignored; release -> one handshake, IDLE, next op accepted.
//  5: reset mid-op: rst_n=0 at cycle 15 of EXP -> out_valid=0, in_ready=1 next cycle; new a=2 -> 0x40000000.
//  6: random a in [1,p-1] x1000 -> (a*out_data) mod p == 1, back-to-back with random out_ready.

Source files
------------

// File: rtl/m31_inverter.sv
// M31 modular inverter: out = a^EXPONENT mod (2^31-1), default exponent p-2 gives a^-1.
// Latency: result valid 32 cycles after operand accept (EXP_BITS iterations + 1 finalise cycle).
// Backpressure: one op in flight; in_ready low while busy or holding a result until out_ready.
module m31_inverter #(
  parameter int                    DATA_WIDTH = 31,
  parameter logic [DATA_WIDTH-1:0] EXPONENT   = 31'h7FFFFFFD,
  parameter int                    EXP_BITS   = 31,
  parameter int                    CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_zero
);

  localparam logic [DATA_WIDTH-1:0] P = '1;  // 2^31-1

  typedef enum logic [1:0] {IDLE, EXP, DONE} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] acc, base;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  zero_q;
  logic                  last;  // all exponent bits consumed; next EXP cycle publishes acc
  logic [DATA_WIDTH-1:0] mul_acc, mul_sq, in_canon;

  // Multiply two canonical M31 elements and fold the 62-bit product back to [0, p-1].
  // 2^31 == 1 mod p, so hi and lo halves simply add; the second fold cannot overflow.
  function automatic logic [DATA_WIDTH-1:0] m31_mul(input logic [DATA_WIDTH-1:0] x,
                                                    input logic [DATA_WIDTH-1:0] y);
    logic [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH:0]     s;
    logic [DATA_WIDTH-1:0]   t;
    prod = (2*DATA_WIDTH)'(x) * (2*DATA_WIDTH)'(y);
    s    = {1'b0, prod[DATA_WIDTH-1:0]} + {1'b0, prod[2*DATA_WIDTH-1:DATA_WIDTH]};
    t    = s[DATA_WIDTH-1:0] + DATA_WIDTH'(s[DATA_WIDTH]);
    return (t == P) ? '0 : t;
  endfunction

  assign mul_acc  = m31_mul(acc, base);
  assign mul_sq   = m31_mul(base, base);
  assign in_canon = (in_data == P) ? '0 : in_data;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = EXP;
      end
      EXP: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Square-and-multiply datapath, scanning exponent bits LSB first; result latched on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      base     <= '0;
      cnt      <= '0;
      zero_q   <= 1'b0;
      last     <= 1'b0;
      out_data <= '0;
      out_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            base   <= in_canon;
            acc    <= DATA_WIDTH'(1);
            cnt    <= '0;
            zero_q <= (in_canon == '0);
            last   <= 1'b0;
          end
        end
        EXP: begin
          if (!last) begin
            if (EXPONENT[cnt]) acc <= mul_acc;
            base <= mul_sq;
            if (cnt == CNT_WIDTH'(EXP_BITS - 1)) last <= 1'b1;
            else                                 cnt  <= cnt + 1'b1;
          end else begin
            out_data <= acc;
            out_zero <= zero_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_m31_inverter.sv
`timescale 1ns/1ps
module tb_m31_inverter;

  localparam longint unsigned P = 64'h7FFFFFFF;
  localparam longint unsigned E = 64'h7FFFFFFD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [30:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [30:0] out_data;
  logic        out_zero;

  int checks = 0;
  int errors = 0;

  m31_inverter dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain modular exponentiation on 64-bit integers.
  function automatic longint unsigned ref_pow(input longint unsigned a);
    longint unsigned b, r, e;
    b = a % P; r = 1; e = E;
    while (e != 0) begin
      if (e[0]) r = (r * b) % P;
      b = (b * b) % P;
      e = e >> 1;
    end
    return r;
  endfunction

  // Present an operand and wait until it is taken; returns at the negedge after the accept edge.
  task automatic start_op(input logic [30:0] a, output bit ok);
    int n;
    ok = 0; n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = a;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (in_ready) begin @(posedge clk); ok = 1; end
    @(negedge clk);
    in_valid = 1'b0; in_data = 31'($urandom);
  endtask

  // Count edges until out_valid is seen; optionally jiggle out_ready while waiting.
  task automatic wait_result(input bit rand_rdy, output int lat, output bit ok);
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (rand_rdy) out_ready = $urandom_range(0, 1);
      @(posedge clk); lat++;
      @(negedge clk);
    end
    ok = out_valid;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 31'd0 || out_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h out_zero=%b, want 1 0 0 0",
               in_ready, out_valid, out_data, out_zero);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_vectors;
    logic [30:0] av [6] = '{31'd2, 31'd3, 31'd1, 31'h7FFFFFFE, 31'd0, 31'h7FFFFFFF};
    logic [30:0] ev [6] = '{31'h40000000, 31'h55555555, 31'd1, 31'h7FFFFFFE, 31'd0, 31'd0};
    bit          zv [6] = '{0, 0, 0, 0, 1, 1};
    bit ok; int lat;
    out_ready = 1'b1;
    foreach (av[i]) begin
      start_op(av[i], ok);
      wait_result(1'b0, lat, ok);
      checks++;
      if (!ok || lat != 32) begin
        errors++;
        $display("FAIL latency a=%h: got %0d cycles (valid=%b), want 32", av[i], lat, ok);
      end
      checks++;
      if (out_data !== ev[i] || out_data !== 31'(ref_pow(64'(av[i])))) begin
        errors++;
        $display("FAIL vector a=%h: out_data=%h, want %h", av[i], out_data, ev[i]);
      end
      checks++;
      if (out_zero !== zv[i]) begin
        errors++;
        $display("FAIL zero flag a=%h: out_zero=%b, want %b", av[i], out_zero, zv[i]);
      end
      @(negedge clk);  // handshake completes with out_ready high
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL return to idle a=%h: out_valid=%b in_ready=%b, want 0 1", av[i], out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok; int lat;
    out_ready = 1'b0;
    start_op(31'd2, ok);
    wait_result(1'b0, lat, ok);
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0]; in_data = 31'd5;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 31'h40000000 || out_zero !== 1'b0) begin
        errors++;
        $display("FAIL backpressure hold c=%0d: valid=%b in_ready=%b data=%h zero=%b, want 1 0 40000000 0",
                 c, out_valid, in_ready, out_data, out_zero);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    start_op(31'd3, ok);
    wait_result(1'b0, lat, ok);
    checks++;
    if (!ok || out_data !== 31'h55555555) begin
      errors++;
      $display("FAIL after backpressure: out_data=%h valid=%b, want 55555555", out_data, ok);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit ok; int lat;
    start_op(31'd12345, ok);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 31'd0 || out_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset mid-op: valid=%b in_ready=%b data=%h zero=%b, want 0 1 0 0",
               out_valid, in_ready, out_data, out_zero);
    end
    rst_n = 1'b1;
    start_op(31'd2, ok);
    wait_result(1'b0, lat, ok);
    checks++;
    if (!ok || lat != 32 || out_data !== 31'h40000000) begin
      errors++;
      $display("FAIL after reset op: data=%h lat=%0d, want 40000000 32", out_data, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bit ok; int lat; int n;
    logic [30:0] a, d;
    longint unsigned prod;
    for (int k = 0; k < 1000; k++) begin
      a = 31'($urandom_range(1, 32'h7FFFFFFE));
      start_op(a, ok);
      wait_result(1'b1, lat, ok);
      d = out_data;
      n = 0;
      while (!out_ready && n < 50) begin
        @(negedge clk); n++;
        out_ready = $urandom_range(0, 1);
        if (out_data !== d) ok = 0;
      end
      out_ready = 1'b1;
      @(posedge clk);
      prod = (64'(a) * 64'(d)) % P;
      checks++;
      if (!ok || prod != 1 || d !== 31'(ref_pow(64'(a))) || out_zero !== 1'b0) begin
        errors++;
        $display("FAIL random op %0d a=%h: out_data=%h (a*out mod p=%0d) zero=%b ok=%b, want %h",
                 k, a, d, prod, out_zero, ok, 31'(ref_pow(64'(a))));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
